slowmem_master: RTL and testbench

//  Initiator side of the slowmem strobe/mfc protocol. Arbitrates two clients
//  (PID0 and PID1 fetch/data ports) onto one slowmem port. Issues one-cycle

---
 rtl/slowmem_master.sv | 116 +++++++++++
 tb/tb_slowmem_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/slowmem_master.sv
// Two-client initiator for the slowmem strobe/mfc protocol: arbitrates req0/req1,
// issues a one-cycle strobe, waits for mfc on reads and returns a one-cycle done.
module slowmem_master #(
  parameter int WIDTH   = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             rnotw0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             done0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             rnotw1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             done1,
  output logic [WIDTH-1:0] rdata1,
  output logic             mem_strobe,
  output logic             mem_rnotw,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_mfc,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             timeout_err
);

  // state | meaning
  // IDLE  | no transaction, arbitrating requests
  // ISSUE | strobe high this cycle, slowmem samples at the next edge
  // WAIT  | read issued, waiting for mfc or timeout
  // DONE  | done pulse high for the granted client
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          gnt;
  logic          pick;

  // On a tie the client not served last wins; a lone requester always wins.
  assign pick = (req0 && req1) ? ~last : req1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      gnt         <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_strobe  <= 1'b0;
      mem_rnotw   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt        <= pick;
            last       <= pick;
            mem_rnotw  <= pick ? rnotw1 : rnotw0;
            mem_addr   <= pick ? addr1 : addr0;
            mem_wdata  <= pick ? wdata1 : wdata0;
            mem_strobe <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_strobe <= 1'b0;
          if (mem_rnotw) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            if (gnt) done1 <= 1'b1;
            else     done0 <= 1'b1;
            state <= DONE;
          end
        end
        WAIT: begin
          if (mem_mfc) begin
            if (gnt) begin rdata1 <= mem_rdata; done1 <= 1'b1; end
            else     begin rdata0 <= mem_rdata; done0 <= 1'b1; end
            state <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            if (gnt) begin rdata1 <= '0; done1 <= 1'b1; end
            else     begin rdata0 <= '0; done0 <= 1'b1; end
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slowmem_master.sv
// Bench for slowmem_master: slowmem model with MEMDELAY=4, table of single-client
// transactions, arbitration, timeout and reset-abort sequences, scoreboard on done.
module tb_slowmem_master;

  localparam int WIDTH = 16;
  localparam int AW = 16;
  localparam int TIMEOUT = 15;
  localparam int MEMDELAY = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 0, rnotw0 = 0, req1 = 0, rnotw1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic done0, done1, mem_strobe, mem_rnotw, mem_mfc, busy, timeout_err;
  logic [WIDTH-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  slowmem_master #(.WIDTH(WIDTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rnotw0(rnotw0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .rnotw1(rnotw1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .mem_strobe(mem_strobe), .mem_rnotw(mem_rnotw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mfc(mem_mfc), .mem_rdata(mem_rdata), .busy(busy), .timeout_err(timeout_err)
  );

  // slowmem model: commits writes at the strobe edge, raises mfc for one cycle
  // MEMDELAY edges after sampling a read strobe. Unaffected by the master reset.
  logic [WIDTH-1:0] mem [256];
  logic             mfc_r = 0, pend = 0, no_mfc = 0, force_mfc = 0;
  logic [2:0]       dly = '0;
  logic [7:0]       raddr = '0;
  logic [WIDTH-1:0] rdata_r = '0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = WIDTH'(i * 3);
    mem[8'h10] = 16'hA5A5;
  end

  assign mem_mfc   = (mfc_r & ~no_mfc) | force_mfc;
  assign mem_rdata = rdata_r;

  always @(posedge clk) begin
    if (mfc_r) mfc_r <= 1'b0;
    if (mem_strobe) begin
      if (!mem_rnotw) mem[mem_addr[7:0]] = mem_wdata;
      else begin
        pend  <= 1'b1;
        dly   <= 3'(MEMDELAY - 1);
        raddr <= mem_addr[7:0];
      end
    end else if (pend) begin
      if (dly == 0) begin
        mfc_r   <= 1'b1;
        rdata_r <= mem[raddr];
        pend    <= 1'b0;
      end else dly <= dly - 3'd1;
    end
  end

  int checks = 0, passes = 0;
  int busy_cyc = 0, strobe_cnt = 0, done_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic             client;
    logic [WIDTH-1:0] rdata;
    logic             chk_data;
    logic             terr;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (mem_strobe) strobe_cnt++;
    if (done0 && done1) check("done_exclusive", {done0, done1}, 2'b01);
    if (done0 || done1) begin
      done_cnt++;
      if (sb.size() == 0) check("unexpected_done", {done0, done1}, 2'b00);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("done_client", {31'd0, done1}, {31'd0, e.client});
        if (e.chk_data) check("rdata", done1 ? rdata1 : rdata0, e.rdata);
        check("timeout_err", timeout_err, e.terr);
      end
    end
  end

  task automatic wait_done(input logic c, output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n++;
      if (c ? done1 : done0) return;
    end
    check("wait_done_bound", 0, 1);
  endtask

  task automatic do_req(input logic c, input logic rn, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] er,
                        input logic terr, input int lat);
    int n, s0;
    exp_t e;
    e.client = c; e.rdata = er; e.chk_data = rn; e.terr = terr;
    sb.push_back(e);
    s0 = strobe_cnt;
    if (c) begin rnotw1 = rn; addr1 = a; wdata1 = wd; req1 = 1; end
    else   begin rnotw0 = rn; addr0 = a; wdata0 = wd; req0 = 1; end
    @(negedge clk);
    check("strobe_issue", {mem_strobe, mem_rnotw}, {1'b1, rn});
    check("strobe_addr", mem_addr, a);
    if (!rn) check("strobe_wdata", mem_wdata, wd);
    wait_done(c, n);
    n++;
    if (c) req1 = 0; else req0 = 0;
    check("latency", n, lat);
    @(negedge clk);
    check("one_strobe", strobe_cnt - s0, 1);
  endtask

  typedef struct {
    logic             client;
    logic             rnotw;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    int               lat;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 1, 16'h0010, 16'h0000, 16'hA5A5, 7};
    vecs[1] = '{0, 0, 16'h0020, 16'h1234, 16'h0000, 2};
    vecs[2] = '{0, 1, 16'h0020, 16'h0000, 16'h1234, 7};
    vecs[3] = '{1, 0, 16'h0030, 16'hBEEF, 16'h0000, 2};
    vecs[4] = '{1, 1, 16'h0030, 16'h0000, 16'hBEEF, 7};
    vecs[5] = '{0, 1, 16'h0030, 16'h0000, 16'hBEEF, 7};
    vecs[6] = '{1, 1, 16'h0005, 16'h0000, 16'h000F, 7};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", {done0, done1}, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);
    check("rst_mem", {mem_strobe, mem_rnotw, mem_addr, mem_wdata}, 0);
    check("rst_terr", timeout_err, 0);
    reset = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (i == 0) busy_cyc = 0;
      do_req(vecs[i].client, vecs[i].rnotw, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, 1'b0, vecs[i].lat);
      if (i == 0) begin
        @(negedge clk);
        check("busy_cycles", busy_cyc, 7);
      end
    end

    // Arbitration after reset: 0 wins the tie, then client0 re-requests while 1 waits.
    reset = 1; @(negedge clk); reset = 0; @(negedge clk);
    begin
      exp_t e;
      int s0;
      e.chk_data = 1; e.terr = 0;
      e.client = 0; e.rdata = 16'hA5A5; sb.push_back(e);
      e.client = 1; e.rdata = 16'h1234; sb.push_back(e);
      e.client = 0; e.rdata = 16'hBEEF; sb.push_back(e);
      s0 = strobe_cnt;
      fork
        begin
          int n;
          rnotw0 = 1; addr0 = 16'h0010; req0 = 1;
          wait_done(0, n);
          addr0 = 16'h0030;
          wait_done(0, n);
          check("second_grant0_latency", n, 16);
          req0 = 0;
        end
        begin
          int n;
          rnotw1 = 1; addr1 = 16'h0020; req1 = 1;
          wait_done(1, n);
          check("grant1_latency", n, 15);
          req1 = 0;
        end
      join
      @(negedge clk);
      check("arb_strobes", strobe_cnt - s0, 3);
      check("arb_sb_drained", sb.size(), 0);
    end

    // Timeout: mfc suppressed, forced completion after TIMEOUT wait cycles.
    no_mfc = 1;
    do_req(0, 1, 16'h0040, 16'h0000, 16'h0000, 1'b1, TIMEOUT + 2);
    no_mfc = 0;
    check("terr_sticky", timeout_err, 1);
    do_req(1, 1, 16'h0010, 16'h0000, 16'hA5A5, 1'b1, 7);
    check("terr_after_good", timeout_err, 1);

    // Reset in WAIT: abort, stray mfc afterwards must not complete anything.
    rnotw1 = 1; addr1 = 16'h0020; req1 = 1;
    repeat (3) @(negedge clk);
    check("in_wait_busy", busy, 1);
    reset = 1; req1 = 0;
    #1;
    check("abort_outputs", {busy, done0, done1, mem_strobe, mem_rnotw, timeout_err}, 0);
    check("abort_data", {rdata0, rdata1, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    reset = 0;
    begin
      int d0;
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      force_mfc = 1; @(negedge clk); force_mfc = 0;
      repeat (3) @(negedge clk);
      check("stray_mfc_busy", busy, 0);
      check("stray_mfc_done", done_cnt - d0, 0);
    end
    do_req(1, 1, 16'h0020, 16'h0000, 16'h1234, 1'b0, 7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
